seg_display_arbiter: RTL
========================

Name: seg_display_arbiter

Overview:
- Shares the board's quad seven-segment display between two requesters, A (index 0) and B (index 1), using a req/grant handshake.
- Drives the four 4-bit digit inputs of the display mux/decoder.
- Enforces a minimum ownership time and inserts a blank interval on every ownership change so digits never tear between sources.
- Round-robin fairness; the output digit and blank registers sit directly in front of the display driver.

Parameters:
- HOLD_CYC, 6000000, minimum clk cycles an owner keeps the display before it can be forced off (must be >= 1).
- BLANK_CYC, 60000, clk cycles the display is blanked between owners (must be >= 1).
- CNT_W, 24, width of the internal hold/blank down-counter; must hold max(HOLD_CYC, BLANK_CYC) - 1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  2  request lines; req[0] = A, req[1] = B; level-held while display is wanted.
- val_a  in  16  A's digits, [15:12] = digit3 ... [3:0] = digit0.
- val_b  in  16  B's digits, same packing.
- grant  out  2  one-hot ownership (or 0); registered.
- val3  out  4  digit 3 to display; registered.
- val2  out  4  digit 2; registered.
- val1  out  4  digit 1; registered.
- val0  out  4  digit 0; registered.
- blank  out  1  1 = display driver must turn all anodes off; registered.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; grant = 0; val3..val0 = 0; blank = 1; counter = 0.
  - last_owner = B, so A wins the first simultaneous request.
- States: IDLE, BLANK, OWN. Internal regs: pend (target owner), owner, last_owner, counter.
- IDLE:
  - No req: stay.
  - Exactly one req: pend = that requester.
  - Both req: pend = !last_owner.
  - On a pend decision: go to BLANK, counter = BLANK_CYC - 1.
- BLANK:
  - grant = 0, blank = 1, vals = 0.
  - If req[pend] = 0: abandon. If the other requester's req = 1, retarget pend to it and reload counter; otherwise go to IDLE.
  - Else if counter == 0: go to OWN, owner = pend, last_owner = pend, grant[pend] = 1, counter = HOLD_CYC - 1.
  - Else decrement counter.
  - BLANK therefore lasts exactly BLANK_CYC cycles.
- OWN:
  - blank = 0; on every edge in OWN (including the entry edge) val3..val0 <= owner's bus, i.e. one-cycle registered latency from the bus.
  - Counter decrements and saturates at 0.
  - Release: req[owner] = 0 → the next edge leaves OWN regardless of the counter. Go to BLANK for the other requester if its req = 1, else to IDLE.
  - Forced handover: counter == 0, req[owner] = 1 and other req = 1 → go to BLANK with pend = other.
  - Counter == 0 with no contender: owner keeps the display indefinitely.
- Release and contention in the same cycle: treated as release; same target, go to BLANK for the other.
- grant always drops on the same edge that blank rises; it is never asserted during BLANK or IDLE.
- Reset mid-operation returns immediately to reset values; no partial digits are held.

Optional Feature:
- Macro: SEG_ARB_PREEMPT_EN.
- Defined: A is high priority. When B owns and req[0] = 1, the next edge forces handover to BLANK with pend = A, ignoring B's remaining hold time. A's own ownership still obeys HOLD_CYC against B.
- Undefined: symmetric round-robin exactly as in Behaviour.

Test Plan (bench: HOLD_CYC = 8, BLANK_CYC = 2):
- Reset, then req = 01 at cycle 0 with val_a = 16'h1234:
  - blank = 1 for 2 cycles after the IDLE→BLANK edge;
  - then grant = 01, blank = 0, {val3..val0} = 1,2,3,4.
  - Changing val_a to 16'hBEEF shows B,E,E,F one cycle later.
- Both req = 11 from reset: A granted first. With both held, B is granted after 8 OWN cycles plus 2 blank cycles; then A again after the next 8 + 2.
- A owns and drops req after 3 cycles with req[1] = 0: next edge grant = 00, blank = 1, vals = 0; state = IDLE.
- B is pending in BLANK and drops req while req[0] = 1: retargets to A; A is granted after a fresh 2 blank cycles.
- Assert rst_n = 0 mid-OWN (A showing 16'h5678): grant = 00, vals = 0, blank = 1 immediately, without waiting for a clock edge.
- With SEG_ARB_PREEMPT_EN: B owns for 2 cycles, then req[0] rises; next edge blank = 1, and A is granted 2 cycles later. Without the macro, A waits for B's full 8-cycle hold.

Source files
------------

// File: rtl/seg_display_arbiter_if.sv
// Bus between the two display requesters and seg_display_arbiter.
// Carries the request/grant handshake, both digit buses and the registered display outputs.
interface seg_display_arbiter_if;
   // req[i] is a level: held high for as long as requester i wants the display.
   // grant[i] is registered and one-hot: it rises only after a full blank interval.
   // It falls on the same edge that blank rises. There is no per-transfer ready.
   logic [1:0]  req;
   logic [15:0] val_a;
   logic [15:0] val_b;
   logic [1:0]  grant;
   logic [3:0]  val3;
   logic [3:0]  val2;
   logic [3:0]  val1;
   logic [3:0]  val0;
   logic        blank;
   logic [1:0]  state;   // debug view of the arbiter FSM: 0 idle, 1 blank, 2 own

   modport master (
      output req, val_a, val_b,
      input  grant, val3, val2, val1, val0, blank, state
   );

   modport slave (
      input  req, val_a, val_b,
      output grant, val3, val2, val1, val0, blank, state
   );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the quad seven-segment display, with a hold time and a blank gap between owners.
// Optional macro SEG_ARB_PREEMPT_EN: requester A preempts B's remaining hold time.
module seg_display_arbiter #(
   parameter int HOLD_CYC  = 6000000,
   parameter int BLANK_CYC = 60000,
   parameter int CNT_W     = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   seg_display_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, OWN = 2'd2} state_t;

   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYC - 1);

   state_t             state_q, state_d;
   logic               pend_q, pend_d;
   logic               owner_q, owner_d;
   logic               last_q, last_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         grant_q, grant_d;
   logic [15:0]        vals_q, vals_d;
   logic               blank_q, blank_d;

   logic               own_req, oth_req, pend_req, alt_req, preempt, leave;
   logic [15:0]        owner_bus, pend_bus;

   assign own_req   = bus.req[owner_q];
   assign oth_req   = bus.req[~owner_q];
   assign pend_req  = bus.req[pend_q];
   assign alt_req   = bus.req[~pend_q];
   assign owner_bus = owner_q ? bus.val_b : bus.val_a;
   assign pend_bus  = pend_q  ? bus.val_b : bus.val_a;

`ifdef SEG_ARB_PREEMPT_EN
   assign preempt = owner_q & bus.req[0];
`else
   assign preempt = 1'b0;
`endif

   // A release always wins over a contention decided in the same cycle; both lead to the same target.
   assign leave = !own_req || (oth_req && ((cnt_q == '0) || preempt));

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      vals_d  = vals_q;
      blank_d = blank_q;
      case (state_q)
         IDLE: begin
            grant_d = 2'b00;
            blank_d = 1'b1;
            vals_d  = 16'h0000;
            if (bus.req != 2'b00) begin
               pend_d  = (bus.req == 2'b11) ? ~last_q : bus.req[1];
               state_d = BLANK;
               cnt_d   = BLANK_LOAD;
            end
         end
         BLANK: begin
            grant_d = 2'b00;
            blank_d = 1'b1;
            vals_d  = 16'h0000;
            if (!pend_req) begin
               if (alt_req) begin
                  pend_d = ~pend_q;
                  cnt_d  = BLANK_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end else if (cnt_q == '0) begin
               state_d = OWN;
               owner_d = pend_q;
               last_d  = pend_q;
               grant_d = pend_q ? 2'b10 : 2'b01;
               blank_d = 1'b0;
               vals_d  = pend_bus;
               cnt_d   = HOLD_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         OWN: begin
            if (leave) begin
               state_d = oth_req ? BLANK : IDLE;
               pend_d  = ~owner_q;
               cnt_d   = BLANK_LOAD;
               grant_d = 2'b00;
               blank_d = 1'b1;
               vals_d  = 16'h0000;
            end else begin
               blank_d = 1'b0;
               vals_d  = owner_bus;
               cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
            blank_d = 1'b1;
            vals_d  = 16'h0000;
         end
      endcase
   end

   // last_q resets to B so that A wins the first simultaneous request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= 1'b0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         grant_q <= 2'b00;
         vals_q  <= 16'h0000;
         blank_q <= 1'b1;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         vals_q  <= vals_d;
         blank_q <= blank_d;
      end
   end

   assign bus.grant = grant_q;
   assign bus.val3  = vals_q[15:12];
   assign bus.val2  = vals_q[11:8];
   assign bus.val1  = vals_q[7:4];
   assign bus.val0  = vals_q[3:0];
   assign bus.blank = blank_q;
   assign bus.state = state_q;

endmodule
